led_matrix_scanner: RTL and testbench

// - Free-running multiplexed driver for an ROWS x COLS LED matrix; replaces the DISPLAY-state scan inside the game FSM.
// - Double-buffers the frame from the logic datapath via valid/ready; swaps only at frame boundaries, so no tearing.
// - Adds per-row PWM brightness, a blink mask (blinking head after game end) and a frame-derived game_tick pulse.
// - game_tick replaces the display-cycle game clock divider.

---
 rtl/snake_pkg.sv | 18 +
 rtl/frame_double_buffer.sv | 40 ++++
 rtl/led_matrix_scanner.sv | 172 +++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game display path.
// The scanner FSM states and row polarity selection live here so the datapath and scanner agree.
package snake_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  // Values for the scanner's ROW_ACTIVE_LOW parameter.
  localparam int ROW_POL_HIGH = 0;  // selected row driven 1 (one-hot)
  localparam int ROW_POL_LOW  = 1;  // selected row driven 0 (one-cold)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/frame_double_buffer.sv
// Pending/display frame registers with a valid/ready input handshake.
// A new frame waits in pending and moves to display only when swap (frame end) fires.
module frame_double_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic [WIDTH-1:0] frame_in,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic             swap,
  output logic [WIDTH-1:0] display
);

  logic [WIDTH-1:0] pending_q;
  logic             full_q;
  logic             accept;

  // Ready comes from state only, so an upstream valid can never loop back into ready.
  assign frame_ready = !full_q;
  assign accept      = frame_valid && !full_q;

  // NOTE: both frame registers are reset, so a restart never shows or swaps in stale pixels.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      pending_q <= '0;
      full_q    <= 1'b0;
      display   <= '0;
    end else if (accept) begin
      // accept needs pending empty and the swap needs it full, so the two never collide
      pending_q <= frame_in;
      full_q    <= 1'b1;
    end else if (swap && full_q) begin
      display   <= pending_q;
      pending_q <= '0;
      full_q    <= 1'b0;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Free-running multiplexed LED matrix scanner with double-buffered frames,
// per-row PWM brightness, a blink mask and a frame-derived game_tick.
module led_matrix_scanner
  import snake_pkg::*;
#(
  parameter int ROWS            = DEF_ROWS,
  parameter int COLS            = DEF_COLS,
  parameter int BRIGHT_BITS     = 3,
  parameter int FRAMES_PER_TICK = 4,
  parameter int BLINK_FRAMES    = 8,
  parameter int ROW_ACTIVE_LOW  = ROW_POL_LOW
) (
  input  logic                   clka,
  input  logic                   restart_n,
  input  logic                   enable,
  input  logic [ROWS*COLS-1:0]   frame_in,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [BRIGHT_BITS-1:0] brightness,
  input  logic [ROWS*COLS-1:0]   blink_mask,
  input  logic                   blink_en,
  output logic [ROWS-1:0]        row_cathode,
  output logic [COLS-1:0]        column_anode,
  output logic                   frame_done,
  output logic                   game_tick
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int TICK_W  = $clog2(FRAMES_PER_TICK + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [ROWS-1:0]        ROWS_OFF   = (ROW_ACTIVE_LOW == ROW_POL_HIGH) ? '0 : '1;
  localparam logic [BRIGHT_BITS-1:0] LAST_PHASE = '1;
  localparam logic [ROW_W-1:0]       LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [TICK_W-1:0]      LAST_TICK  = TICK_W'(FRAMES_PER_TICK - 1);
  localparam logic [BLINK_W-1:0]     LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

  scan_state_e            state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [BRIGHT_BITS-1:0] phase_q, phase_d;
  logic [BRIGHT_BITS-1:0] br_q, br_d;
  logic                   frame_end;

  logic [TICK_W-1:0]      tick_cnt_q;
  logic [BLINK_W-1:0]     blink_cnt_q;
  logic                   blink_phase_q;
  logic                   blink_off;

  logic [ROWS*COLS-1:0]   display;
  logic [ROWS-1:0]        row_sel;
  logic [ROWS-1:0]        row_cathode_d;
  logic [COLS-1:0]        column_anode_d;

  frame_double_buffer #(
    .WIDTH(ROWS * COLS)
  ) u_buffer (
    .clka        (clka),
    .restart_n   (restart_n),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .swap        (frame_end),
    .display     (display)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      phase_q <= '0;
      br_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      br_q    <= br_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    phase_d   = phase_q;
    br_d      = (state_q == BLANK) ? brightness : br_q;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      row_d   = '0;
      phase_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          row_d   = '0;
          phase_d = '0;
        end
        BLANK: begin
          state_d = DRIVE;
          phase_d = '0;
        end
        DRIVE: begin
          if (phase_q == LAST_PHASE) begin
            state_d   = BLANK;
            phase_d   = '0;
            frame_end = (row_q == LAST_ROW);
            row_d     = frame_end ? '0 : row_q + 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output values are computed from the next state so the registered pins line up with state_q.
  assign blink_off = blink_en && !blink_phase_q;

  always_comb begin
    row_sel        = '0;
    column_anode_d = '0;
    if (state_d == DRIVE) begin
      row_sel[row_d] = 1'b1;
      if (phase_d < br_d) begin
        column_anode_d = display[int'(row_d)*COLS +: COLS] &
                         ~(blink_off ? blink_mask[int'(row_d)*COLS +: COLS] : '0);
      end
    end
    row_cathode_d = row_sel ^ ROWS_OFF;
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      row_cathode  <= ROWS_OFF;
      column_anode <= '0;
      frame_done   <= 1'b0;
      game_tick    <= 1'b0;
    end else begin
      row_cathode  <= row_cathode_d;
      column_anode <= column_anode_d;
      frame_done   <= frame_end;
      game_tick    <= frame_end && (tick_cnt_q == LAST_TICK);
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      tick_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      if (frame_end) begin
        tick_cnt_q <= (tick_cnt_q == LAST_TICK) ? '0 : tick_cnt_q + 1'b1;
      end
      // blinking disabled parks the blink state in "on" so re-enabling starts a fresh period
      if (!blink_en) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b1;
      end else if (frame_end) begin
        if (blink_cnt_q == LAST_BLINK) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= !blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed self-checking bench for led_matrix_scanner at default parameters (8x8, 3-bit PWM).
// Each frame is captured into per-row activity summaries and compared with hand-derived values.
module tb_led_matrix_scanner;

  logic        clka = 1'b0;
  logic        restart_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic [2:0]  brightness = '0;
  logic [63:0] blink_mask = '0;
  logic        blink_en = 1'b0;
  logic        frame_ready;
  logic [7:0]  row_cathode;
  logic [7:0]  column_anode;
  logic        frame_done;
  logic        game_tick;

  led_matrix_scanner dut (
    .clka         (clka),
    .restart_n    (restart_n),
    .enable       (enable),
    .frame_in     (frame_in),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .brightness   (brightness),
    .blink_mask   (blink_mask),
    .blink_en     (blink_en),
    .row_cathode  (row_cathode),
    .column_anode (column_anode),
    .frame_done   (frame_done),
    .game_tick    (game_tick)
  );

  always #5 clka = ~clka;

  localparam logic [63:0] FRAME_BIT0 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] FRAME_A    = 64'h0000_0000_A500_000F;
  localparam logic [63:0] FRAME_B    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] FRAME_C    = 64'h0000_0000_0000_0300;

  int n_checks = 0;
  int n_pass   = 0;

  // per-frame capture results
  int          act_cnt [8];
  logic [7:0]  col_seen [8];
  logic [7:0]  lit_mask [8];
  int          fd_mid, tick_mid, ready_ones, bad;
  logic        ready_first, fd_end, tick_end, ready_end;
  int          frame_no = 0;
  logic [23:0] tick_hist = '0;
  int          fd_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  function automatic logic [7:0] col_all();
    logic [7:0] acc = '0;
    for (int r = 0; r < 8; r++) acc |= col_seen[r];
    return acc;
  endfunction

  function automatic int act_total();
    int s = 0;
    for (int r = 0; r < 8; r++) s += act_cnt[r];
    return s;
  endfunction

  // Called on the sample where the scanner sits in BLANK row 0; steps through the
  // whole frame and stops on the sample that should carry frame_done.
  task automatic capture_frame(input logic [63:0] fin_next, input logic valid_next);
    logic [7:0] act;
    for (int r = 0; r < 8; r++) begin
      act_cnt[r]  = 0;
      col_seen[r] = '0;
      lit_mask[r] = '0;
    end
    fd_mid = 0; tick_mid = 0; ready_ones = 0; bad = 0;
    for (int i = 1; i <= 72; i++) begin
      step();
      if (i == 1) begin
        ready_first = frame_ready;
        frame_in    = fin_next;
        frame_valid = valid_next;
      end
      if (i < 72) begin
        if (frame_done) fd_mid++;
        if (game_tick) tick_mid++;
        if (frame_ready) ready_ones++;
        act = ~row_cathode;
        if ($countones(act) > 1) bad++;
        else if (act == 8'h00) begin
          if (column_anode != 8'h00) bad++;
        end else begin
          for (int r = 0; r < 8; r++) begin
            if (act[r]) begin
              if (column_anode != 8'h00 && act_cnt[r] < 8) lit_mask[r][act_cnt[r]] = 1'b1;
              col_seen[r] |= column_anode;
              act_cnt[r]++;
            end
          end
        end
      end else begin
        fd_end    = frame_done;
        tick_end  = game_tick;
        ready_end = frame_ready;
      end
    end
    if (frame_no < 24) tick_hist[frame_no] = tick_end;
    frame_no++;
  endtask

  initial begin
    blink_en   = 1'b1;
    blink_mask = 64'h0000_0000_0000_0200;
    brightness = 3'd7;
    #12;
    check("rst_rows", row_cathode, 8'hFF);
    check("rst_cols", column_anode, 8'h00);
    check("rst_ready", frame_ready, 1'b1);
    check("rst_pulses", {frame_done, game_tick}, 2'b00);
    step();
    restart_n = 1'b1;
    step();

    // frame 0: display still empty, bit-0 frame waits in pending
    enable = 1'b1; frame_valid = 1'b1; frame_in = FRAME_BIT0;
    step();
    check("blank0_ready", frame_ready, 1'b0);
    check("blank0_rows", row_cathode, 8'hFF);
    capture_frame(FRAME_BIT0, 1'b0);
    check("f0_row0_drive", act_cnt[0], 8);
    check("f0_rows_total", act_total(), 64);
    check("f0_dark", col_all(), 8'h00);
    check("f0_ready_low", ready_ones, 0);
    check("f0_done_at_72", fd_end, 1'b1);
    check("f0_no_early_done", fd_mid, 0);
    check("f0_ready_after_swap", ready_end, 1'b1);

    // frame 1: bit 0 shown at brightness 7
    capture_frame(FRAME_BIT0, 1'b0);
    check("f1_row0_phases", lit_mask[0], 8'h7F);
    check("f1_row0_cols", col_seen[0], 8'h01);
    check("f1_other_rows", col_all() & 8'hFF & ~col_seen[0] | (col_all() ^ col_seen[0]), 8'h00);
    check("f1_row7_drive", act_cnt[7], 8);
    check("f1_one_row", bad, 0);

    // frame 2: brightness 0 keeps columns dark while rows still scan
    brightness = 3'd0;
    capture_frame(FRAME_BIT0, 1'b0);
    check("f2_dark", col_all(), 8'h00);
    check("f2_rows_scan", act_total(), 64);

    // frame 3: brightness 3; A accepted, B offered while pending is full
    brightness = 3'd3;
    frame_in = FRAME_A; frame_valid = 1'b1;
    capture_frame(FRAME_B, 1'b1);
    check("f3_row0_phases", lit_mask[0], 8'h07);
    check("f3_shown_unchanged", col_seen[0], 8'h01);
    check("f3_ready_held_low", ready_ones, 0);
    check("f3_ready_after_swap", ready_end, 1'b1);

    // frame 4: A on display, B accepted the cycle after the swap
    brightness = 3'd7;
    capture_frame(FRAME_B, 1'b0);
    check("f4_b_accepted", ready_first, 1'b0);
    check("f4_row0", col_seen[0], 8'h0F);
    check("f4_row3", col_seen[3], 8'hA5);
    check("f4_row3_phases", lit_mask[3], 8'h7F);
    check("f4_pending_full", ready_ones, 0);

    // frame 5: B on display, C loaded behind it
    frame_in = FRAME_C; frame_valid = 1'b1;
    capture_frame(FRAME_C, 1'b0);
    check("f5_row7", col_seen[7], 8'h80);
    check("f5_row0", col_seen[0], 8'h00);

    // frames 6..23: C on display; pixel (1,1) blinks, (1,0) stays lit
    fd_cnt = 0;
    for (int f = 6; f < 24; f++) begin
      capture_frame(FRAME_C, 1'b0);
      fd_cnt += fd_mid + tick_mid + bad;
      if (f == 7 || f == 8 || f == 15 || f == 16 || f == 23)
        check($sformatf("blink_f%0d", f), col_seen[1], (f >= 8 && f < 16) ? 8'h01 : 8'h03);
    end
    check("blink_mid_glitches", fd_cnt, 0);
    check("tick_pattern", tick_hist, 24'h888888);

    // enable drops at row 5 of frame 24
    for (int i = 0; i < 48; i++) step();
    check("row5_active", row_cathode, 8'hDF);
    enable = 1'b0;
    step();
    check("dis_rows", row_cathode, 8'hFF);
    check("dis_cols", column_anode, 8'h00);
    frame_valid = 1'b1; frame_in = 64'hFFFF_FFFF_FFFF_FFFF;
    fd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_done || game_tick) fd_cnt++;
    end
    frame_valid = 1'b0;
    check("dis_no_done", fd_cnt, 0);
    check("dis_handshake", frame_ready, 1'b0);

    // resume at row 0; blink is in its off half-period (frames 24-31)
    enable = 1'b1;
    step();
    check("resume_blank", row_cathode, 8'hFF);
    step();
    check("resume_row0", row_cathode, 8'hFE);
    for (int i = 0; i < 10; i++) step();
    check("resume_row1", row_cathode, 8'hFD);
    check("resume_row1_cols", column_anode, 8'h01);

    // asynchronous restart mid-DRIVE
    restart_n = 1'b0;
    #2;
    check("arst_rows", row_cathode, 8'hFF);
    check("arst_cols", column_anode, 8'h00);
    check("arst_ready", frame_ready, 1'b1);
    check("arst_pulses", {frame_done, game_tick}, 2'b00);
    restart_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
